// File: rtl/rr_sel_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin bus-select arbiter.
interface rr_sel_arbiter_if #(
  parameter int SEL = 5
);
  localparam int N = 2**SEL;

  logic [N-1:0]   req;
  logic           done;
  logic [SEL-1:0] ctrl_sel;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           timeout_err;

  modport master (output req, done, input ctrl_sel, gnt, busy, timeout_err);
  modport slave  (input req, done, output ctrl_sel, gnt, busy, timeout_err);
endinterface

// File: rtl/rr_sel_arbiter.sv
// Round-robin owner arbiter driving the select of an N:1 shared-bus mux (N = 2**SEL).
// Define ARB_TIMEOUT_EN to bound each tenure to MAX_HOLD cycles with a timeout_err pulse.
module rr_sel_arbiter #(
  parameter int SEL      = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  rr_sel_arbiter_if.slave  bus
);
  localparam int N = 2**SEL;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [SEL-1:0] sel_q, sel_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic [SEL-1:0] ptr_q, ptr_d;
  logic [SEL-1:0] scan_ptr;
  logic [SEL-1:0] win;
  logic           rel;
  logic           to_fire;

  if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_hold
    $error("rr_sel_arbiter: MAX_HOLD must be in 1..65535");
  end

  // First requester at or after p, scanning upward modulo N.
  function automatic logic [SEL-1:0] pick(input logic [N-1:0] r, input logic [SEL-1:0] p);
    logic [SEL-1:0] idx;
    logic           found;
    pick  = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = p + SEL'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    ptr_d    = ptr_q;
    rel      = 1'b0;
    scan_ptr = ptr_q;
    if (state_q == GRANT) begin
      rel = bus.done || !bus.req[sel_q] || to_fire;
      if (rel) begin
        ptr_d    = sel_q + 1'b1;
        scan_ptr = sel_q + 1'b1;
      end
    end
    win = pick(bus.req, scan_ptr);
    // Releasing owner sits last in the new scan, so it only wins when it is alone.
    if (state_q == IDLE || rel) begin
      if (|bus.req) begin
        state_d = GRANT;
        sel_d   = win;
        gnt_d   = N'(1) << win;
        busy_d  = 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [15:0] hold_q;
  logic        err_q;
  logic        grant_ev;

  assign grant_ev = (state_q == IDLE || rel) && (|bus.req);
  // A done or withdrawal on the same edge is a normal release, not a timeout.
  assign to_fire  = (state_q == GRANT) && (hold_q == 16'(MAX_HOLD - 1)) &&
                    !bus.done && bus.req[sel_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= to_fire;
      if (grant_ev)
        hold_q <= '0;
      else if (state_q == GRANT)
        hold_q <= hold_q + 16'd1;
    end
  end

  assign bus.timeout_err = err_q;
`else
  assign to_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.ctrl_sel = sel_q;
  assign bus.gnt      = gnt_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed scenarios plus random traffic checked against a tenure-level model.
module tb_rr_sel_arbiter;
  localparam int SEL      = 2;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rr_sel_arbiter_if #(.SEL(SEL)) bus ();

  rr_sel_arbiter #(.SEL(SEL), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string name, input int sel, input int g, input int b, input int e);
    chk({name, ".ctrl_sel"}, 32'(bus.ctrl_sel), sel);
    chk({name, ".gnt"}, 32'(bus.gnt), g);
    chk({name, ".busy"}, 32'(bus.busy), b);
    chk({name, ".timeout_err"}, 32'(bus.timeout_err), e);
  endtask

  // Tenure-level model: who owns the bus, where the rotation starts, how long the tenure has run.
  int m_owner, m_ptr, m_hold, m_sel, m_nxt, worst;
  bit m_err, m_rel, m_tmo;
  int wait_cnt [N];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_sel = 0; m_err = 0; worst = 0;
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
    end else begin
      m_err = 0; m_rel = 0; m_tmo = 0;
      foreach (wait_cnt[i]) if (!bus.req[i]) wait_cnt[i] = 0;
      if (m_owner >= 0) begin
        m_tmo = TMO && (m_hold == MAX_HOLD - 1) && !bus.done && bus.req[m_owner];
        m_rel = bus.done || !bus.req[m_owner] || m_tmo;
        if (m_rel) m_ptr = (m_owner + 1) % N;
        else       m_hold++;
        m_err = m_tmo;
      end
      if (m_owner < 0 || m_rel) begin
        if (bus.req != '0) begin
          m_nxt = -1;
          for (int k = 0; k < N; k++)
            if (m_nxt < 0 && bus.req[(m_ptr + k) % N]) m_nxt = (m_ptr + k) % N;
          for (int i = 0; i < N; i++)
            if (i != m_nxt && bus.req[i]) wait_cnt[i]++;
          wait_cnt[m_nxt] = 0;
          m_owner = m_nxt; m_sel = m_nxt; m_hold = 0;
        end else begin
          m_owner = -1;
        end
      end
      foreach (wait_cnt[i]) if (wait_cnt[i] > worst) worst = wait_cnt[i];
    end
  end

  // Every-cycle comparison of the DUT against the model.
  initial begin
    forever begin
      @(posedge clk); #1;
      chk("cyc.ctrl_sel", 32'(bus.ctrl_sel), m_sel);
      chk("cyc.gnt", 32'(bus.gnt), (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
      chk("cyc.busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk("cyc.timeout_err", 32'(bus.timeout_err), 32'(m_err));
      chk("cyc.onehot0", 32'($onehot0(bus.gnt)), 1);
      chk("cyc.gnt_sel_busy", 32'(bus.gnt[bus.ctrl_sel]), 32'(bus.busy));
      chk("cyc.fairness", (worst < N) ? 32'd1 : 32'd0, 1);
    end
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    rst_n = 1'b0; bus.req = '0; bus.done = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      expect_out("idle", 0, 4'b0000, 0, 0);
    end

    @(negedge clk); bus.req = 4'b0100;
    @(posedge clk); #1;
    expect_out("single", 2, 4'b0100, 1, 0);
    repeat (3) @(negedge clk);
    bus.done = 1'b1; bus.req = 4'b0000;
    @(posedge clk); #1;
    expect_out("release_idle", 2, 4'b0000, 0, 0);
    chk("model.ptr_after_release", m_ptr, 3);
    @(negedge clk); bus.done = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    expect_out("after_reset", 0, 4'b0000, 0, 0);

    @(negedge clk); bus.req = 4'b1111;
    @(posedge clk); #1;
    expect_out("rr0", 0, 4'b0001, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); bus.done = 1'b1;
      @(posedge clk); #1;
      expect_out("rr_grant", k % 4, 1 << (k % 4), 1, 0);
      @(negedge clk); bus.done = 1'b0;
      @(posedge clk); #1;
      expect_out("rr_hold", k % 4, 1 << (k % 4), 1, 0);
    end

    @(negedge clk); bus.req = 4'b1001; bus.done = 1'b1;
    @(posedge clk); #1;
    expect_out("own3", 3, 4'b1000, 1, 0);
    @(negedge clk); bus.done = 1'b0;
    @(negedge clk); bus.done = 1'b1;
    @(posedge clk); #1;
    expect_out("wrap0", 0, 4'b0001, 1, 0);
    @(negedge clk); bus.done = 1'b0;
    @(negedge clk); bus.done = 1'b1;
    @(posedge clk); #1;
    expect_out("back3", 3, 4'b1000, 1, 0);

    @(negedge clk); bus.req = 4'b0010;
    @(posedge clk); #1;
    expect_out("own1", 1, 4'b0010, 1, 0);
    @(negedge clk); bus.done = 1'b0; bus.req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      expect_out("no_preempt", 1, 4'b0010, 1, 0);
    end
    @(negedge clk); bus.req = 4'b0001;
    @(posedge clk); #1;
    expect_out("withdraw", 0, 4'b0001, 1, 0);

    @(negedge clk); bus.req = 4'b0010;
    @(posedge clk); #1;
    expect_out("hold_grant", 1, 4'b0010, 1, 0);
`ifdef ARB_TIMEOUT_EN
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      expect_out("pre_timeout", 1, 4'b0010, 1, 0);
    end
    @(posedge clk); #1;
    expect_out("timeout", 1, 4'b0010, 1, 1);
    @(posedge clk); #1;
    expect_out("post_timeout", 1, 4'b0010, 1, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); bus.done = 1'b1;
    @(posedge clk); #1;
    expect_out("done_beats_timeout", 1, 4'b0010, 1, 0);
    @(negedge clk); bus.done = 1'b0;
`else
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      expect_out("unbounded", 1, 4'b0010, 1, 0);
    end
`endif

    @(negedge clk); #2 rst_n = 1'b0;
    #1 expect_out("async_reset", 0, 4'b0000, 0, 0);
    bus.req = '0; bus.done = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) bus.req[i] = ~bus.req[i];
      bus.done = ($urandom_range(3) == 0);
    end

    @(posedge clk); #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
